// File: rtl/comparator_bist_pkg.sv
// Shared types and the golden comparator function for the comparator BIST.
package comparator_bist_pkg;

  localparam int STATE_W = 3;
  localparam int MAX_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Golden {h,e,l}; operands are zero-extended to MAX_W by the caller, unsigned.
  function automatic logic [2:0] exp_hel(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
    return {a > b, a == b, a < b};
  endfunction

endpackage

// File: rtl/comparator_bist_if.sv
// BIST <-> comparator connection: operands out, {h,e,l} results back.
interface comparator_bist_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic             h_i;
  logic             e_i;
  logic             l_i;

  modport master (output a_o, output b_o, input  h_i, input  e_i, input  l_i);
  modport slave  (input  a_o, input  b_o, output h_i, output e_i, output l_i);
endinterface

// File: rtl/comparator_bist_golden.sv
// Combinational reference {h,e,l} for the operands currently driven by the BIST.
module comparator_bist_golden
  import comparator_bist_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [2:0]       hel_o
);
  assign hel_o = exp_hel(MAX_W'(a_i), MAX_W'(b_i));
endmodule

// File: rtl/comparator_bist.sv
// Exhaustive sweep driver/checker for a magnitude comparator.
// Optional STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module comparator_bist
  import comparator_bist_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  comparator_bist_if.master  cmp,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);
  localparam int VW = 2 * WIDTH;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           state_q;
  logic [VW-1:0]    vec_q;
  logic [SW-1:0]    set_q;
  logic [WIDTH-1:0] a_q, b_q, fa_q, fb_q;
  logic [ERR_W-1:0] err_q;
  logic             busy_q, done_q, pass_q, ff_q;

  logic [2:0] hel_exp;
  logic       mismatch;
  logic       last_vec;

  comparator_bist_golden #(.WIDTH(WIDTH)) u_golden (
    .a_i   (a_q),
    .b_i   (b_q),
    .hel_o (hel_exp)
  );

  assign mismatch = ({cmp.h_i, cmp.e_i, cmp.l_i} != hel_exp);

  // Final vector is decoded explicitly so the sweep never relies on counter wrap.
`ifdef STOP_ON_FAIL_EN
  assign last_vec = (vec_q == '1) || mismatch;
`else
  assign last_vec = (vec_q == '1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      set_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      ff_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          vec_q   <= '0;
          err_q   <= '0;
          fa_q    <= '0;
          fb_q    <= '0;
          pass_q  <= 1'b0;
          ff_q    <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= ST_DRIVE;
        end
        ST_DRIVE: begin
          a_q     <= vec_q[VW-1:WIDTH];
          b_q     <= vec_q[WIDTH-1:0];
          set_q   <= '0;
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (set_q == SW'(SETTLE - 1)) state_q <= ST_CHECK;
          else                          set_q   <= set_q + SW'(1);
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_q != '1) err_q <= err_q + ERR_W'(1);
            if (!ff_q) begin
              ff_q <= 1'b1;
              fa_q <= a_q;
              fb_q <= b_q;
            end
          end
          if (last_vec) state_q <= ST_DONE;
          else begin
            vec_q   <= vec_q + VW'(1);
            state_q <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          pass_q  <= (err_q == '0);
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmp.a_o = a_q;
  assign cmp.b_o = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
  assign fail_a  = fa_q;
  assign fail_b  = fb_q;

endmodule

// File: tb/tb_comparator_bist.sv
// Directed + randomized-fault checks of comparator_bist (WIDTH=2, SETTLE=2, ERR_W=3).
module tb_comparator_bist;
  localparam int W      = 2;
  localparam int S      = 2;
  localparam int EW     = 3;
  localparam int NV     = 1 << (2 * W);
  localparam int VCOST  = S + 2;

  logic clk, rst_n, start;
  logic busy, done, pass;
  logic [EW-1:0] err_cnt;
  logic [W-1:0]  fail_a, fail_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] mask [NV];
  logic [2:0] hel;

  comparator_bist_if #(.WIDTH(W)) cif ();

  comparator_bist #(.WIDTH(W), .SETTLE(S), .ERR_W(EW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cmp     (cif),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt),
    .fail_a  (fail_a),
    .fail_b  (fail_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ideal(input int v);
    int a, b;
    a = v / (1 << W);
    b = v % (1 << W);
    return {a > b, a == b, a < b};
  endfunction

  // Comparator under test: ideal behaviour with an injected per-vector fault mask.
  always_comb begin
    hel = ideal(int'({cif.a_o, cif.b_o})) ^ mask[{cif.a_o, cif.b_o}];
  end
  assign cif.h_i = hel[2];
  assign cif.e_i = hel[1];
  assign cif.l_i = hel[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mask(input int mode);
    for (int v = 0; v < NV; v++) begin
      case (mode)
        1:       mask[v] = ideal(v) & 3'b010;
        2:       mask[v] = (ideal(v) & 3'b101) != 0 ? 3'b101 : 3'b000;
        3:       mask[v] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        default: mask[v] = 3'b000;
      endcase
    end
  endtask

  task automatic run_sweep(input bit repulse, output int done_cyc, output int npulse,
                           output bit seq_ok, output int last_v);
    done_cyc = -1;
    npulse   = 0;
    seq_ok   = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = repulse && (c == 3 || c == 10);
      if (done) begin
        npulse++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy && int'({cif.a_o, cif.b_o}) != (c - 1) / VCOST) seq_ok = 1'b0;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    start  = 1'b0;
    last_v = int'({cif.a_o, cif.b_o});
  endtask

  task automatic do_test(input string tag, input int mode, input bit repulse);
    int nf, first, exp_done, exp_last, exp_err;
    int done_cyc, npulse, last_v;
    bit seq_ok, stop;
`ifdef STOP_ON_FAIL_EN
    stop = 1'b1;
`else
    stop = 1'b0;
`endif
    set_mask(mode);
    nf = 0; first = -1;
    for (int v = 0; v < NV; v++) begin
      if (mask[v] != 3'b000) begin
        if (first < 0) first = v;
        nf++;
        if (stop) break;
      end
    end
    exp_err  = (nf > (1 << EW) - 1) ? (1 << EW) - 1 : nf;
    exp_done = (stop && first >= 0) ? (first + 1) * VCOST + 1 : NV * VCOST + 1;
    exp_last = (stop && first >= 0) ? first : NV - 1;

    run_sweep(repulse, done_cyc, npulse, seq_ok, last_v);
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_npulse"},   npulse, 1);
    chk({tag, "_seq"},      {31'd0, seq_ok}, 1);
    chk({tag, "_err_cnt"},  err_cnt, exp_err);
    chk({tag, "_pass"},     pass, (nf == 0) ? 1 : 0);
    chk({tag, "_fail_a"},   fail_a, (first >= 0) ? first / (1 << W) : 0);
    chk({tag, "_fail_b"},   fail_b, (first >= 0) ? first % (1 << W) : 0);
    chk({tag, "_last_ab"},  last_v, exp_last);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_mask(0);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err",  err_cnt, 0);
    chk("rst_fail", {fail_a, fail_b}, 0);
    chk("rst_ab",   {cif.a_o, cif.b_o}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_test("clean_repulse", 0, 1'b1);
    do_test("e_stuck0",      1, 1'b0);
    do_test("hl_swap",       2, 1'b0);
    for (int i = 0; i < 4; i++) do_test($sformatf("rand%0d", i), 3, 1'b0);

    // Mid-sweep reset: outputs drop without waiting for a clock edge.
    set_mask(2);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_err",  err_cnt, 0);
    chk("abort_ab",   {cif.a_o, cif.b_o}, 0);
    chk("abort_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_idle", {busy, done}, 0);
    end
    do_test("post_abort", 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
